cornet_bus_arbiter: RTL and testbench
=====================================

// Module: cornet_bus_arbiter
// PURPOSE
//  Shares the single cornet memory bus between NREQ requesters (CPU fetch, CPU data, video/DMA).
//  Accepts per-requester byte read/write requests and grants one at a time.
//  Drives the memory-side rd_req/rd_ack and wr_enable handshake, then returns data plus a one-cycle ack.
//  Sits between the cornet CPU / peripherals and the memory/IO decoder.
// PARAMETERS
//  NREQ     3    number of requesters (2..4)
//  PRIO0    1    1: requester 0 has strict priority; 0: pure round-robin
//  TIMEOUT  255  max cycles to wait for mem_rd_ack before abort (1..255)
// PORTS
//  clk            in   1         system clock
//  reset          in   1         synchronous, active-high reset
//  req_valid      in   NREQ      request pending, held until req_ack seen
//  req_we         in   NREQ      1 = write, 0 = read
//  req_addr       in   NREQ*16   byte address, requester i at [16*i +: 16]
//  req_wdata      in   NREQ*8    write data, requester i at [8*i +: 8]
//  req_ack        out  NREQ      one-cycle completion pulse, one-hot
//  req_rdata      out  8         read data, valid in the req_ack cycle
//  req_err        out  1         high with req_ack when the read timed out
//  mem_addr       out  16        memory bus address
//  mem_wr_data    out  8         memory write data
//  mem_wr_enable  out  1         one-cycle write strobe
//  mem_rd_req     out  1         read request, held until mem_rd_ack
//  mem_rd_ack     in   1         read done; mem_rd_data valid this cycle
//  mem_rd_data    in   8         memory read data
//  grant_id       out  2         index of the current or last granted requester
//  busy           out  1         high in any state other than IDLE
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high.
//  - Reset: all outputs 0; state = IDLE; last = NREQ-1, so requester 0 wins first under round-robin; timeout counter = 0.
//  - States: IDLE, WRITE, READ, ACK.
//  - IDLE: candidates = req_valid & ~mask.
//    - If PRIO0 and candidate 0 is set -> winner 0.
//    - Otherwise the first candidate scanning last+1, last+2, ... (mod NREQ) wins.
//    - On a winner, registered in the same edge: mem_addr, mem_wr_data, grant_id, busy = 1.
//    - Next state: WRITE if req_we is set, else READ with mem_rd_req = 1. No candidate -> stay in IDLE.
//  - WRITE: mem_wr_enable = 1 for exactly this one cycle -> ACK.
//  - READ: mem_rd_req stays high and the counter increments each cycle.
//    - mem_rd_ack = 1: capture req_rdata <= mem_rd_data; mem_rd_req <= 0; -> ACK.
//    - Counter reaches TIMEOUT without ack: mem_rd_req <= 0; req_rdata <= 8'hFF; req_err <= 1; -> ACK.
//    - If ack and timeout land in the same cycle, the ack wins.
//  - ACK: req_ack[grant_id] = 1 for one cycle; last <= grant_id; -> IDLE.
//    - busy is still high in this cycle; req_err and req_ack clear on the next edge.
//  - Latency from grant edge to ack: write = 2 cycles; read = (cycles until mem_rd_ack) + 1.
//  - mask: in the first IDLE cycle after ACK, the requester just served is masked. This covers its one-cycle deassert delay.
//    - mask is 0 otherwise, so back-to-back requests from one requester lose at most 1 cycle.
//  - req_valid dropped mid-transaction: the transaction still completes and req_ack is still pulsed.
//    - mem_* values were latched at grant and do not follow later requester changes.
//  - mem_rd_ack outside READ is ignored.
//  - Reset in any state: next edge returns to the reset values. No req_ack is issued and the in-flight access is abandoned.
//  - Arithmetic: round-robin index wraps mod NREQ; counter is 8 bits and saturates; grant_id upper bits are 0 when NREQ < 4.
// TESTING
//  - Single read:
//    - Stimulus: req0 reads 0x0444; memory acks 3 cycles later with 0xA9.
//    - Required: mem_rd_req high for 3 cycles; req_ack = 3'b001 with req_rdata = 0xA9; req_err = 0.
//  - Single write:
//    - Stimulus: req2 writes 0x5A to 0x9000.
//    - Required: mem_wr_enable high for 1 cycle with mem_addr 0x9000 and mem_wr_data 0x5A; req_ack = 3'b100 on the following cycle.
//  - Round-robin (PRIO0 = 0):
//    - Stimulus: req0/1/2 held valid continuously, zero-wait memory.
//    - Required: grant order 0,1,2,0,1,2; no requester is granted twice in a row.
//  - Priority (PRIO0 = 1):
//    - Stimulus: req1 and req2 pending; req0 asserts during req1's read.
//    - Required: req1 completes; req0 is granted next; req2 waits.
//  - Timeout (TIMEOUT = 8):
//    - Stimulus: memory never acks.
//    - Required: mem_rd_req drops after 8 cycles; req_ack with req_rdata = 0xFF and req_err = 1; next request proceeds normally.
//  - Reset mid-read:
//    - Stimulus: reset asserted for 1 cycle while in READ.
//    - Required: all outputs 0 at the next edge and no req_ack; requester 0 wins the first grant after reset.

Source files
------------

// File: rtl/cornet_bus_arbiter.sv
// Shares the cornet memory bus between NREQ requesters: one byte read or write at a time,
// with optional strict priority for requester 0 and a read-ack timeout.
module cornet_bus_arbiter #(
    parameter int NREQ    = 3,
    parameter int PRIO0   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*16-1:0]   req_addr,
    input  logic [NREQ*8-1:0]    req_wdata,
    output logic [NREQ-1:0]      req_ack,
    output logic [7:0]           req_rdata,
    output logic                 req_err,
    output logic [15:0]          mem_addr,
    output logic [7:0]           mem_wr_data,
    output logic                 mem_wr_enable,
    output logic                 mem_rd_req,
    input  logic                 mem_rd_ack,
    input  logic [7:0]           mem_rd_data,
    output logic [1:0]           grant_id,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

    localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [1:0]      LAST_RST = 2'(NREQ - 1);
    localparam logic [7:0]      TO_LAST  = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        grant_q, grant_d;
    logic [NREQ-1:0]   mask_q, mask_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [15:0]       addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_req_q, rd_req_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   cand;
    logic              win_found;
    logic [1:0]        win_idx;
    logic              win_we;
    logic [15:0]       win_addr;
    logic [7:0]        win_wdata;

    // Winner selection: optional strict priority for requester 0, else scan from last+1.
    always_comb begin
        cand      = req_valid & ~mask_q;
        win_found = 1'b0;
        win_idx   = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (PRIO0 != 0 && cand[0]) begin
            win_found = 1'b1;
        end
        for (int i = 1; i <= NREQ; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!win_found && cand[k] && k == (int'(last_q) + i) % NREQ) begin
                    win_found = 1'b1;
                    win_idx   = 2'(k);
                end
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == 2'(k)) begin
                win_we    = req_we[k];
                win_addr  = req_addr[16*k +: 16];
                win_wdata = req_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        mask_d   = '0;
        ack_d    = '0;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        wr_en_d  = 1'b0;
        rd_req_d = rd_req_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    cnt_d   = '0;
                    if (win_we) begin
                        state_d = WRITE;
                        wr_en_d = 1'b1;
                    end else begin
                        state_d  = READ;
                        rd_req_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_d = ACK;
                ack_d   = ONE << grant_q;
            end
            READ: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                // A late ack in the timeout cycle still delivers real data.
                if (mem_rd_ack) begin
                    rdata_d  = mem_rd_data;
                    rd_req_d = 1'b0;
                    ack_d    = ONE << grant_q;
                    state_d  = ACK;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d  = 8'hFF;
                    err_d    = 1'b1;
                    rd_req_d = 1'b0;
                    ack_d    = ONE << grant_q;
                    state_d  = ACK;
                end
            end
            ACK: begin
                last_d  = grant_q;
                mask_d  = ONE << grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= LAST_RST;
            grant_q  <= '0;
            mask_q   <= '0;
            ack_q    <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            wr_en_q  <= 1'b0;
            rd_req_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            mask_q   <= mask_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            wr_en_q  <= wr_en_d;
            rd_req_q <= rd_req_d;
            err_q    <= err_d;
        end
    end

    assign req_ack       = ack_q;
    assign req_rdata     = rdata_q;
    assign req_err       = err_q;
    assign mem_addr      = addr_q;
    assign mem_wr_data   = wdata_q;
    assign mem_wr_enable = wr_en_q;
    assign mem_rd_req    = rd_req_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cornet_bus_arbiter.sv
// Bench for cornet_bus_arbiter: directed scenarios, then random traffic on a round-robin
// and a priority instance checked against a transaction-level arbitration model.
module tb_cornet_bus_arbiter;

    localparam int N  = 3;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   [2];
    logic [N-1:0]  rv    [2];
    logic [N-1:0]  rwe   [2];
    logic [N*16-1:0] raddr [2];
    logic [N*8-1:0]  rwd   [2];
    logic [N-1:0]  ack   [2];
    logic [7:0]    rdata [2];
    logic          err   [2];
    logic [15:0]   maddr [2];
    logic [7:0]    wdat  [2];
    logic          wen   [2];
    logic          rrq   [2];
    logic          mack  [2];
    logic [7:0]    mrd   [2];
    logic [1:0]    gid   [2];
    logic          busy  [2];

    cornet_bus_arbiter #(.NREQ(N), .PRIO0(0), .TIMEOUT(TO)) u_rr (
        .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_we(rwe[0]), .req_addr(raddr[0]),
        .req_wdata(rwd[0]), .req_ack(ack[0]), .req_rdata(rdata[0]), .req_err(err[0]),
        .mem_addr(maddr[0]), .mem_wr_data(wdat[0]), .mem_wr_enable(wen[0]), .mem_rd_req(rrq[0]),
        .mem_rd_ack(mack[0]), .mem_rd_data(mrd[0]), .grant_id(gid[0]), .busy(busy[0]));

    cornet_bus_arbiter #(.NREQ(N), .PRIO0(1), .TIMEOUT(TO)) u_pr (
        .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_we(rwe[1]), .req_addr(raddr[1]),
        .req_wdata(rwd[1]), .req_ack(ack[1]), .req_rdata(rdata[1]), .req_err(err[1]),
        .mem_addr(maddr[1]), .mem_wr_data(wdat[1]), .mem_wr_enable(wen[1]), .mem_rd_req(rrq[1]),
        .mem_rd_ack(mack[1]), .mem_rd_data(mrd[1]), .grant_id(gid[1]), .busy(busy[1]));

    int errors = 0;
    int checks = 0;

    // Transaction-level model state per instance.
    int         mst   [2];
    int         cur   [2];
    int         k     [2];
    int         dly   [2];
    int         last  [2];
    int         mask  [2];
    logic       cwe   [2];
    logic [7:0] cdata [2];
    bit         prio  [2] = '{1'b0, 1'b1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    function automatic logic [63:0] outs(input int d);
        return {ack[d], rdata[d], err[d], maddr[d], wdat[d], wen[d], rrq[d], gid[d], busy[d]};
    endfunction

    // Arbitration rule: requester 0 first when prioritised, else first valid after 'lst'.
    function automatic int pick(input logic [N-1:0] cand, input int lst, input bit pr);
        if (pr && cand[0]) return 0;
        for (int i = 1; i <= N; i++) if (cand[(lst + i) % N]) return (lst + i) % N;
        return -1;
    endfunction

    task automatic wait_ack(input int d, input logic [2:0] exp, input string tag);
        int n;
        n = 0;
        do begin nedge(); n++; end while (ack[d] === 3'b000 && n < 30);
        chk(tag, ack[d], exp);
    endtask

    task automatic do_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rv[d] = '0; rwe[d] = '0; mack[d] = 1'b0;
        end
        nedge();
        rst[0] = 1'b0; rst[1] = 1'b0;
    endtask

    task automatic step(input int d);
        logic [2:0] mb;
        int  w, tgt;
        bit  done;
        done = 1'b0;
        case (mst[d])
            0: begin
                mb = (mask[d] < 0) ? 3'b000 : (3'b001 << mask[d]);
                w = pick(rv[d] & ~mb, last[d], prio[d]);
                mask[d] = -1;
                if (w < 0) begin
                    chk("rnd_idle", {busy[d], ack[d], wen[d], rrq[d]}, '0);
                end else begin
                    cur[d] = w; cwe[d] = rwe[d][w]; k[d] = 0;
                    dly[d] = $urandom_range(1, TO + 3);
                    cdata[d] = 8'($urandom);
                    chk("rnd_grant", {busy[d], gid[d], maddr[d], wdat[d], wen[d], rrq[d], ack[d]},
                        {1'b1, 2'(w), raddr[d][16*w +: 16], rwd[d][8*w +: 8], cwe[d], ~cwe[d], 3'b000});
                    mst[d] = 1;
                end
            end
            1: begin
                k[d]++;
                tgt = (dly[d] <= TO) ? dly[d] : TO;
                if (cwe[d]) begin
                    chk("rnd_wack", {busy[d], ack[d], err[d], wen[d], rrq[d]},
                        {1'b1, 3'b001 << cur[d], 1'b0, 1'b0, 1'b0});
                    done = 1'b1;
                end else if (k[d] < tgt) begin
                    chk("rnd_rwait", {busy[d], rrq[d], ack[d]}, {1'b1, 1'b1, 3'b000});
                end else begin
                    chk("rnd_rack", {busy[d], ack[d], rdata[d], err[d], rrq[d]},
                        {1'b1, 3'b001 << cur[d], (dly[d] <= TO) ? cdata[d] : 8'hFF, dly[d] > TO, 1'b0});
                    done = 1'b1;
                end
                if (done) begin last[d] = cur[d]; mst[d] = 2; end
            end
            default: begin
                chk("rnd_post", {busy[d], ack[d], err[d], wen[d], rrq[d]}, '0);
                mask[d] = last[d];
                mst[d] = 0;
            end
        endcase
        // Memory: ack in the chosen READ cycle, noise on the ack line otherwise.
        if (mst[d] == 1 && !cwe[d]) begin
            mack[d] = (k[d] + 1 == dly[d]);
            mrd[d]  = (k[d] + 1 == dly[d]) ? cdata[d] : 8'($urandom);
        end else begin
            mack[d] = 1'($urandom_range(0, 1));
            mrd[d]  = 8'($urandom);
        end
        for (int i = 0; i < N; i++) begin
            if (done && i == cur[d]) begin
                rv[d][i] = 1'b0;
            end else if (mst[d] == 1 && i == cur[d]) begin
                raddr[d][16*i +: 16] = 16'($urandom);
                if ($urandom_range(0, 3) == 0) rv[d][i] = 1'b0;
            end else if (!rv[d][i] && $urandom_range(0, 2) == 0) begin
                rv[d][i] = 1'b1;
                rwe[d][i] = 1'($urandom_range(0, 1));
                raddr[d][16*i +: 16] = 16'($urandom);
                rwd[d][8*i +: 8] = 8'($urandom);
            end
        end
    endtask

    initial begin
        int cnt;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rv[d] = '0; rwe[d] = '0; raddr[d] = '0; rwd[d] = '0;
            mack[d] = 1'b0; mrd[d] = '0;
        end
        nedge(); nedge();
        chk("reset_rr", outs(0), '0);
        chk("reset_pr", outs(1), '0);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Single read: ack in the third READ cycle.
        rv[0] = 3'b001; raddr[0][15:0] = 16'h0444;
        nedge();
        chk("rd_grant", {busy[0], gid[0], maddr[0], rrq[0]}, {1'b1, 2'd0, 16'h0444, 1'b1});
        nedge();
        chk("rd_req_c2", rrq[0], 1'b1);
        nedge();
        chk("rd_req_c3", rrq[0], 1'b1);
        mack[0] = 1'b1; mrd[0] = 8'hA9;
        nedge();
        chk("rd_ack", {ack[0], rdata[0], err[0], rrq[0]}, {3'b001, 8'hA9, 1'b0, 1'b0});
        mack[0] = 1'b0; rv[0] = '0;
        nedge();
        chk("rd_done", {ack[0], busy[0]}, '0);

        // Single write.
        rv[0] = 3'b100; rwe[0] = 3'b100; raddr[0][47:32] = 16'h9000; rwd[0][23:16] = 8'h5A;
        nedge();
        chk("wr_strobe", {wen[0], maddr[0], wdat[0], ack[0]}, {1'b1, 16'h9000, 8'h5A, 3'b000});
        nedge();
        chk("wr_ack", {wen[0], ack[0]}, {1'b0, 3'b100});
        rv[0] = '0; rwe[0] = '0;
        nedge();

        // Timeout: memory never acks.
        rv[0] = 3'b010; raddr[0][31:16] = 16'h1234;
        nedge();
        cnt = 0;
        while (rrq[0] === 1'b1 && cnt < 20) begin cnt++; nedge(); end
        chk("to_len", cnt, TO);
        chk("to_resp", {ack[0], rdata[0], err[0]}, {3'b010, 8'hFF, 1'b1});
        rv[0] = '0;
        nedge();
        chk("to_clear", {ack[0], err[0]}, '0);
        rv[0] = 3'b010; mack[0] = 1'b1; mrd[0] = 8'h77;
        wait_ack(0, 3'b010, "to_next_ack");
        chk("to_next_data", {rdata[0], err[0]}, {8'h77, 1'b0});
        rv[0] = '0; mack[0] = 1'b0;

        // Round-robin with all requesters held and zero-wait memory.
        do_reset();
        rv[0] = 3'b111; mack[0] = 1'b1;
        for (int i = 0; i < 6; i++) wait_ack(0, 3'b001 << (i % 3), "rr_order");
        rv[0] = '0; mack[0] = 1'b0;

        // Strict priority: req0 arrives during req1's read and overtakes req2.
        rv[1] = 3'b110;
        nedge();
        chk("pr_first", {busy[1], gid[1]}, {1'b1, 2'd1});
        rv[1][0] = 1'b1;
        nedge();
        mack[1] = 1'b1;
        wait_ack(1, 3'b010, "pr_ack1");
        rv[1][1] = 1'b0;
        wait_ack(1, 3'b001, "pr_ack0");
        rv[1][0] = 1'b0;
        wait_ack(1, 3'b100, "pr_ack2");
        rv[1] = '0; mack[1] = 1'b0;

        // Reset while a read is in flight.
        rv[0] = 3'b001; raddr[0][15:0] = 16'h0ABC;
        nedge();
        chk("rst_inflight", rrq[0], 1'b1);
        rst[0] = 1'b1; rv[0] = 3'b111;
        nedge();
        chk("rst_mid", outs(0), '0);
        rst[0] = 1'b0;
        nedge();
        chk("rst_regrant", {busy[0], gid[0], maddr[0], ack[0]}, {1'b1, 2'd0, 16'h0ABC, 3'b000});
        mack[0] = 1'b1;
        wait_ack(0, 3'b001, "rst_ack0");
        rv[0] = '0; mack[0] = 1'b0;

        // Random traffic on both instances.
        do_reset();
        for (int d = 0; d < 2; d++) begin
            mst[d] = 0; last[d] = N - 1; mask[d] = -1; cur[d] = 0; k[d] = 0; dly[d] = 1;
            cwe[d] = 1'b0; cdata[d] = '0;
        end
        repeat (3000) begin
            nedge();
            step(0);
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
